// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search helper for mux_rr_arbiter.
// The search works on a fixed 32-bit request vector, so DEPTH may be at most 32.
package mux_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int unsigned ARB_MAX_REQ = 32;
  localparam int unsigned ARB_IDX_W   = 5;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] index;
  } rr_pick_t;

  // The caller zero-extends a narrower request vector. Because the unused upper
  // bits are never set, a search modulo 32 finds the same winner as a search
  // modulo DEPTH.
  function automatic rr_pick_t rr_next(input logic [ARB_MAX_REQ-1:0] valid,
                                       input logic [ARB_IDX_W-1:0]   start);
    rr_pick_t             pick;
    logic [ARB_IDX_W-1:0] idx;
    pick = '0;
    // Scan from the farthest offset to the nearest; the nearest hit is written last and wins.
    for (int k = ARB_MAX_REQ - 1; k >= 0; k--) begin
      idx = start + ARB_IDX_W'(k);
      if (valid[idx]) begin
        pick.found = 1'b1;
        pick.index = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/multiplexer.sv
// Generic DEPTH:1 multiplexer of WIDTH-bit words.
// An address outside 0..DEPTH-1 yields zero.
module multiplexer #(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic [WIDTH-1:0]      data_in [DEPTH],
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      data_out
);

  always_comb begin
    // NOTE: data_out gets a default before the loop, so no path can leave it unassigned and infer a latch.
    data_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) data_out = data_in[i];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin valid/ready arbiter that owns the select of one shared data mux.
// Define MUX_ARB_LOCK_EN to add the req_lock port, which holds the grant for bursts.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH-1:0]      req_valid,
  input  logic [WIDTH-1:0]      req_data [DEPTH],
`ifdef MUX_ARB_LOCK_EN
  input  logic [DEPTH-1:0]      req_lock,
`endif
  output logic [DEPTH-1:0]      req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_src,
  output logic                  busy
);

  arb_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_grant;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_grant_inc;
  logic [ADDR_WIDTH-1:0] w_search_start;
  logic [ADDR_WIDTH-1:0] w_winner;
  logic                  w_hold;
  rr_pick_t              w_pick;

`ifdef MUX_ARB_LOCK_EN
  assign w_hold = req_lock[r_grant];
`else
  assign w_hold = 1'b0;
`endif

  assign w_grant_inc = (r_grant == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_grant + ADDR_WIDTH'(1);

  // In IDLE the search starts at ptr. In GRANT it starts just past the current
  // grant, which makes the requester that has just transferred the last one tried.
  assign w_search_start = (r_state == ARB_GRANT) ? w_grant_inc : r_ptr;
  assign w_pick         = rr_next(ARB_MAX_REQ'(req_valid), ARB_IDX_W'(w_search_start));
  assign w_winner       = ADDR_WIDTH'(w_pick.index);

  assign busy      = (r_state == ARB_GRANT);
  assign out_valid = busy & req_valid[r_grant];
  assign out_src   = r_grant;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[r_grant] = out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick.found) begin
            r_grant <= w_winner;
            r_state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!req_valid[r_grant]) begin
            r_state <= ARB_IDLE;
          end else if (out_ready && !w_hold) begin
            r_ptr <= w_grant_inc;
            if (w_pick.found) r_grant <= w_winner;
            else              r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  multiplexer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mux (
    .data_in  (req_data),
    .addr     (r_grant),
    .data_out (out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a randomized
// run against a behavioural round-robin model. Define MUX_ARB_LOCK_EN to cover locking.
module tb_mux_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DEPTH-1:0] req_valid;
  logic [WIDTH-1:0] req_data [DEPTH];
  logic [DEPTH-1:0] req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [AW-1:0]    out_src;
  logic             busy;
`ifdef MUX_ARB_LOCK_EN
  logic [DEPTH-1:0] req_lock;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_busy;
  int m_grant;
  int m_ptr;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef MUX_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy)
  );

  function automatic int rr_search(int start, logic [DEPTH-1:0] v);
    for (int k = 0; k < DEPTH; k++) begin
      if (v[(start + k) % DEPTH]) return (start + k) % DEPTH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_grant = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    int   w;
    logic lock;
    lock = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lock = req_lock[m_grant];
`endif
    if (!m_busy) begin
      w = rr_search(m_ptr, req_valid);
      if (w >= 0) begin
        m_grant = w;
        m_busy  = 1'b1;
      end
    end else if (!req_valid[m_grant]) begin
      m_busy = 1'b0;
    end else if (out_ready && !lock) begin
      m_ptr = (m_grant + 1) % DEPTH;
      w     = rr_search(m_ptr, req_valid);
      if (w >= 0) m_grant = w;
      else        m_busy  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < DEPTH; i++) req_data[i] = WIDTH'($urandom);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    req_lock  = '0;
`endif
    randomize_data();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    randomize_data();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (req_ready !== '0)   $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0)      $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (out_src !== '0)     $display("FAIL reset_out_src got=%0d exp=0", out_src); else n_pass++;
    rst_n     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    req_valid   = 4'b0001;
    req_data[0] = 8'hA5;
    out_ready   = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_idle_valid got=%b exp=0", out_valid); else n_pass++;
    tick();
    #1;
    n_checks++; if (out_valid !== 1'b1)    $display("FAIL single_valid got=%b exp=1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA5)    $display("FAIL single_data got=%h exp=a5", out_data); else n_pass++;
    n_checks++; if (out_src !== 2'd0)      $display("FAIL single_src got=%0d exp=0", out_src); else n_pass++;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready); else n_pass++;
    req_valid = '0;
    tick();
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_release_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (out_src !== AW'(i % DEPTH)) $display("FAIL b2b_src[%0d] got=%0d exp=%0d", i, out_src, i % DEPTH); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); else n_pass++;
      n_checks++; if (out_data !== req_data[i % DEPTH]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, req_data[i % DEPTH]); else n_pass++;
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] exp_d;
    apply_reset();
    req_valid = 4'b0100;
    out_ready = 1'b0;
    tick();
    exp_d = req_data[2];
    for (int i = 0; i < 5; i++) begin
      req_data[0] = WIDTH'($urandom);
      req_data[1] = WIDTH'($urandom);
      req_data[3] = WIDTH'($urandom);
      #1;
      n_checks++; if (out_src !== 2'd2)   $display("FAIL stall_src[%0d] got=%0d exp=2", i, out_src); else n_pass++;
      n_checks++; if (out_data !== exp_d) $display("FAIL stall_data[%0d] got=%h exp=%h", i, out_data, exp_d); else n_pass++;
      n_checks++; if (req_ready !== '0)   $display("FAIL stall_ready[%0d] got=%b exp=0000", i, req_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL stall_release_ready got=%b exp=0100", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    apply_reset();
    req_valid = 4'b0001;
    out_ready = 1'b1;
    tick();
    req_valid = 4'b0011;
    tick();
    #1;
    n_checks++; if (out_src !== 2'd1) $display("FAIL wd_grant_src got=%0d exp=1", out_src); else n_pass++;
    out_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL wd_valid_drop got=%b exp=0", out_valid); else n_pass++;
    tick();
    #1;
    n_checks++; if (busy !== 1'b0)    $display("FAIL wd_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (out_src !== 2'd1) $display("FAIL wd_src_hold got=%0d exp=1", out_src); else n_pass++;
    req_valid = 4'b1001;
    tick();
    #1;
    n_checks++; if (out_src !== 2'd3) $display("FAIL wd_search_from_ptr got=%0d exp=3", out_src); else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b1) $display("FAIL arst_pre busy=%b valid=%b exp=1/1", busy, out_valid); else n_pass++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (req_ready !== '0)   $display("FAIL arst_ready got=%b exp=0000", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0)      $display("FAIL arst_busy got=%b exp=0", busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    n_checks++; if (out_src !== 2'd0) $display("FAIL arst_ptr_cleared got=%0d exp=0", out_src); else n_pass++;
    req_valid = '0;
    tick();
    tick();
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    int seq [4] = '{0, 1, 1, 1};
    apply_reset();
    req_valid = 4'b1111;
    req_lock  = 4'b0010;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      n_checks++; if (out_src !== AW'(seq[i])) $display("FAIL lock_src[%0d] got=%0d exp=%0d", i, out_src, seq[i]); else n_pass++;
    end
    req_lock = '0;
    tick();
    #1;
    n_checks++; if (out_src !== 2'd2) $display("FAIL lock_release_src got=%0d exp=2", out_src); else n_pass++;
    req_valid = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [DEPTH-1:0] exp_ready;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) req_valid = DEPTH'($urandom);
      out_ready = ($urandom_range(3) != 0);
`ifdef MUX_ARB_LOCK_EN
      req_lock  = ($urandom_range(1) == 0) ? '0 : DEPTH'($urandom);
`endif
      randomize_data();
      #1;
      exp_ready = '0;
      if (m_busy && out_ready) exp_ready[m_grant] = 1'b1;
      n_checks++; if (busy !== m_busy) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_busy); else n_pass++;
      n_checks++; if (out_src !== AW'(m_grant)) $display("FAIL rnd_src c=%0d got=%0d exp=%0d", c, out_src, m_grant); else n_pass++;
      n_checks++; if (out_valid !== (m_busy && req_valid[m_grant])) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, m_busy && req_valid[m_grant]); else n_pass++;
      n_checks++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); else n_pass++;
      if (m_busy) begin
        n_checks++; if (out_data !== req_data[m_grant]) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, req_data[m_grant]); else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    req_lock  = '0;
`endif
    randomize_data();
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_withdraw();
    test_async_reset();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
